// File: rtl/pfd_multi.sv
// pfd_multi - parametrised phase/frequency detector for the DPLL.
//
// Compares the reference pulse f_ref against the oscillator feedback pulse
// f_fb. While a measurement is open, every cycle in which only the reference
// is high counts up cnt_ref and every cycle in which only the feedback is
// high counts up cnt_fb. When both inputs are low again the signed
// difference cnt_ref - cnt_fb is published on phase_err with a one-cycle
// err_valid strobe. A measurement that never closes drops into a timeout
// state. Independently of the detector, the spacing between consecutive
// f_ref rising edges is measured and published on period.
//
// Ports:
//   Clock      in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   en         in   enable; low returns the FSM to IDLE and clears counters
//   f_ref      in   reference pulse input
//   f_fb       in   feedback pulse input
//   phase_err  out  [N_BIT:0] two's-complement cnt_ref - cnt_fb
//   err_valid  out  one-cycle strobe, phase_err updated this cycle
//   lead_fb    out  1 = feedback rose first in the last measurement
//   timeout    out  level, high while the FSM sits in the timeout state
//   period     out  [N_BIT-1:0] cycles between f_ref rising edges, saturating
//   per_valid  out  one-cycle strobe, period updated this cycle
//
// Build option:
//   PFD_SYNC_EN  when defined, f_ref and f_fb each pass through a two-flop
//                synchroniser ahead of the input register (two extra cycles
//                of latency, counts unchanged). When undefined the inputs
//                must already be synchronous to Clock.

module pfd_multi #(
    parameter int N_BIT       = 8,
    parameter int TIMEOUT_CYC = 510
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             en,
    input  logic             f_ref,
    input  logic             f_fb,
    output logic [N_BIT:0]   phase_err,
    output logic             err_valid,
    output logic             lead_fb,
    output logic             timeout,
    output logic [N_BIT-1:0] period,
    output logic             per_valid
);

    // The timeout counter is two bits wider than the overlap counters so
    // that TIMEOUT_CYC may exceed the overlap counter range.
    localparam int               TMO_W    = N_BIT + 2;
    localparam logic [N_BIT-1:0] CNT_MAX  = {N_BIT{1'b1}};
    localparam logic [N_BIT-1:0] CNT_ONE  = {{(N_BIT-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TIMED_OUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ref_in;
    logic              fb_in;
    logic              r;
    logic              b;
    logic              r_d;
    logic [N_BIT-1:0]  cnt_ref;
    logic [N_BIT-1:0]  cnt_fb;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [N_BIT-1:0]  per_cnt;
    logic              per_armed;
    logic              ref_only;
    logic              fb_only;
    logic              both_low;
    logic              r_rise;

`ifdef PFD_SYNC_EN
    logic [1:0] ref_sync;
    logic [1:0] fb_sync;

    // Two-flop synchronisers for pins that may be asynchronous to Clock.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ref_sync <= 2'b00;
            fb_sync  <= 2'b00;
        end else begin
            ref_sync <= {ref_sync[0], f_ref};
            fb_sync  <= {fb_sync[0], f_fb};
        end
    end

    assign ref_in = ref_sync[1];
    assign fb_in  = fb_sync[1];
`else
    assign ref_in = f_ref;
    assign fb_in  = f_fb;
`endif

    // Input register; everything downstream looks only at r and b. r_d is
    // the previous r, used to find reference rising edges for the period.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r   <= 1'b0;
            b   <= 1'b0;
            r_d <= 1'b0;
        end else begin
            r   <= ref_in;
            b   <= fb_in;
            r_d <= r;
        end
    end

    assign ref_only = r & ~b;
    assign fb_only  = b & ~r;
    assign both_low = ~r & ~b;
    assign r_rise   = r & ~r_d;

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Losing enable always wins; inside MEASURE a
    // closing both-low cycle wins over the timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (r | b) begin
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (both_low) begin
                        state_nxt = IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_nxt = TIMED_OUT;
                    end
                end
                TIMED_OUT: begin
                    if (both_low) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign timeout = (state == TIMED_OUT);

    // Detector datapath. The first active cycle is counted on the way out
    // of IDLE, so a measurement's counts cover every cycle from the first
    // high input up to the closing both-low cycle. phase_err and lead_fb
    // are only written here and otherwise hold their last value.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_ref   <= '0;
            cnt_fb    <= '0;
            tmo_cnt   <= '0;
            phase_err <= '0;
            err_valid <= 1'b0;
            lead_fb   <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            if (!en) begin
                cnt_ref <= '0;
                cnt_fb  <= '0;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (r | b) begin
                            lead_fb <= fb_only;
                            cnt_ref <= {{(N_BIT-1){1'b0}}, ref_only};
                            cnt_fb  <= {{(N_BIT-1){1'b0}}, fb_only};
                            tmo_cnt <= '0;
                        end
                    end
                    MEASURE: begin
                        if (both_low) begin
                            phase_err <= {1'b0, cnt_ref} - {1'b0, cnt_fb};
                            err_valid <= 1'b1;
                        end
                        if (ref_only && (cnt_ref != CNT_MAX)) begin
                            cnt_ref <= cnt_ref + CNT_ONE;
                        end
                        if (fb_only && (cnt_fb != CNT_MAX)) begin
                            cnt_fb <= cnt_fb + CNT_ONE;
                        end
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Period measurement, independent of the FSM and of en. The first
    // reference edge after reset only arms the path because there is no
    // earlier edge to measure against.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            per_cnt   <= '0;
            per_armed <= 1'b0;
            period    <= '0;
            per_valid <= 1'b0;
        end else begin
            per_valid <= 1'b0;
            if (r_rise) begin
                per_cnt   <= '0;
                per_armed <= 1'b1;
                if (per_armed) begin
                    period    <= (per_cnt == CNT_MAX) ? CNT_MAX : (per_cnt + CNT_ONE);
                    per_valid <= 1'b1;
                end
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pfd_multi.sv
// tb_pfd_multi - self-checking bench for pfd_multi.
//
// Pulse waveforms are built as per-cycle sample queues; a reference model
// scans the same samples and works out the expected phase error and lead
// flag by counting ref-only and fb-only cycles. A monitor records every
// err_valid and per_valid strobe so each scenario can check strobe count,
// value and timing afterwards.

module tb_pfd_multi;

    localparam int N_BIT       = 8;
    localparam int TIMEOUT_CYC = 510;
    localparam int CNT_MAX     = (1 << N_BIT) - 1;
`ifdef PFD_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             Clock  = 1'b0;
    logic             nReset = 1'b1;
    logic             en     = 1'b0;
    logic             f_ref  = 1'b0;
    logic             f_fb   = 1'b0;
    logic [N_BIT:0]   phase_err;
    logic             err_valid;
    logic             lead_fb;
    logic             timeout;
    logic [N_BIT-1:0] period;
    logic             per_valid;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [N_BIT:0] val;
        logic           lead;
        int             cyc;
    } err_ev_t;

    err_ev_t          err_q[$];
    logic [N_BIT-1:0] per_q[$];
    logic             wave_r[$];
    logic             wave_b[$];

    pfd_multi #(
        .N_BIT       (N_BIT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .en        (en),
        .f_ref     (f_ref),
        .f_fb      (f_fb),
        .phase_err (phase_err),
        .err_valid (err_valid),
        .lead_fb   (lead_fb),
        .timeout   (timeout),
        .period    (period),
        .per_valid (per_valid)
    );

    // Free-running clock and a cycle counter that advances on each edge.
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Record every strobe on the falling edge, away from the active edge.
    always @(negedge Clock) begin
        if (err_valid === 1'b1) err_q.push_back('{val: phase_err, lead: lead_fb, cyc: cyc});
        if (per_valid === 1'b1) per_q.push_back(period);
    end

    // Hard stop in case something stalls the sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Build one pulse: leader alone for g1 cycles (lead_kind 0 = ref,
    // 1 = fb, 2 = both rise together), ov cycles with both high, then the
    // trailing input alone for g2 cycles (tail_kind 0 = ref, 1 = fb,
    // 2 = both fall together).
    task automatic build_wave(input int lead_kind, input int g1, input int ov,
                              input int tail_kind, input int g2);
        wave_r.delete();
        wave_b.delete();
        if (lead_kind != 2) begin
            repeat (g1) begin
                wave_r.push_back(lead_kind == 0);
                wave_b.push_back(lead_kind == 1);
            end
        end
        repeat (ov) begin
            wave_r.push_back(1'b1);
            wave_b.push_back(1'b1);
        end
        if (tail_kind != 2) begin
            repeat (g2) begin
                wave_r.push_back(tail_kind == 0);
                wave_b.push_back(tail_kind == 1);
            end
        end
    endtask

    // Reference model: count ref-only and fb-only cycles from the first
    // active sample to the first both-low sample, each capped at the
    // counter maximum; lead is fb-only on the first active sample.
    function automatic void model_pulse(output int exp_err, output logic exp_lead);
        int cr = 0;
        int cf = 0;
        bit started = 0;
        exp_lead = 1'b0;
        foreach (wave_r[i]) begin
            if (!started && (wave_r[i] || wave_b[i])) begin
                started  = 1;
                exp_lead = wave_b[i] & ~wave_r[i];
            end
            if (started) begin
                if (!wave_r[i] && !wave_b[i]) break;
                if (wave_r[i] && !wave_b[i] && cr < CNT_MAX) cr++;
                if (wave_b[i] && !wave_r[i] && cf < CNT_MAX) cf++;
            end
        end
        exp_err = cr - cf;
    endfunction

    // Play the current waveform one sample per cycle, then drive both low
    // and idle. fall_cyc is the cycle at which the pins went low.
    task automatic drive_wave(input int idle, output int fall_cyc);
        foreach (wave_r[i]) begin
            f_ref = wave_r[i];
            f_fb  = wave_b[i];
            @(negedge Clock);
        end
        f_ref    = 1'b0;
        f_fb     = 1'b0;
        fall_cyc = cyc;
        tick(idle);
    endtask

    // Reset with a short train of single-cycle reference pulses whose
    // rising edges are spaced by sp[i] cycles.
    task automatic ref_edge_train(input int sp[$]);
        f_ref  = 1'b0;
        f_fb   = 1'b0;
        nReset = 1'b0;
        tick(2);
        nReset = 1'b1;
        tick(2);
        per_q.delete();
        for (int i = 0; i <= sp.size(); i++) begin
            f_ref = 1'b1;
            tick(1);
            f_ref = 1'b0;
            if (i < sp.size()) tick(sp[i] - 1);
        end
        tick(8);
    endtask

    // Asynchronous reset must clear outputs before any clock edge; after
    // release with quiet inputs nothing may strobe.
    task automatic test_reset();
        #1 nReset = 1'b0;
        #1;
        n_cmp++;
        if ({phase_err, err_valid, lead_fb, timeout, period, per_valid} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_async outputs: got %h want 0",
                     {phase_err, err_valid, lead_fb, timeout, period, per_valid});
        end
        tick(3);
        nReset = 1'b1;
        en     = 1'b1;
        tick(20);
        n_cmp++;
        if (err_q.size() != 0 || per_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle strobes: got %0d err/%0d per want 0/0",
                     err_q.size(), per_q.size());
        end
        n_cmp++;
        if ({phase_err, err_valid, lead_fb, timeout, period, per_valid} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle outputs: got %h want 0",
                     {phase_err, err_valid, lead_fb, timeout, period, per_valid});
        end
    endtask

    // Reference leads by 5, overlap 3, both fall together -> +5.
    task automatic test_ref_leads();
        int fall, pre, exp_err;
        logic exp_lead;
        logic [N_BIT:0] exp_bits;
        build_wave(0, 5, 3, 2, 0);
        model_pulse(exp_err, exp_lead);
        exp_bits = (N_BIT+1)'(exp_err);
        pre = err_q.size();
        drive_wave(6, fall);
        n_cmp++;
        if (err_q.size() != pre + 1) begin
            n_fail++;
            $display("[TB] FAIL ref_leads strobes: got %0d want 1", err_q.size() - pre);
        end else begin
            n_cmp++;
            if (err_q[pre].val !== exp_bits) begin
                n_fail++;
                $display("[TB] FAIL ref_leads model: got %h want %h", err_q[pre].val, exp_bits);
            end
            n_cmp++;
            if (err_q[pre].cyc != fall + LAT + 1) begin
                n_fail++;
                $display("[TB] FAIL ref_leads latency: got cycle %0d want %0d",
                         err_q[pre].cyc, fall + LAT + 1);
            end
            n_cmp++;
            if (err_q[pre].lead !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL ref_leads lead_fb: got %b want 0", err_q[pre].lead);
            end
        end
        n_cmp++;
        if (phase_err !== 9'd5) begin
            n_fail++;
            $display("[TB] FAIL ref_leads phase_err: got %h want 005", phase_err);
        end
    endtask

    // Feedback leads by 7, overlap 3, reference tail 2 -> -5 (1FB).
    task automatic test_fb_leads();
        int fall, pre, exp_err;
        logic exp_lead;
        logic [N_BIT:0] exp_bits;
        build_wave(1, 7, 3, 0, 2);
        model_pulse(exp_err, exp_lead);
        exp_bits = (N_BIT+1)'(exp_err);
        pre = err_q.size();
        drive_wave(6, fall);
        n_cmp++;
        if (err_q.size() != pre + 1) begin
            n_fail++;
            $display("[TB] FAIL fb_leads strobes: got %0d want 1", err_q.size() - pre);
        end else begin
            n_cmp++;
            if (err_q[pre].val !== exp_bits) begin
                n_fail++;
                $display("[TB] FAIL fb_leads model: got %h want %h", err_q[pre].val, exp_bits);
            end
            n_cmp++;
            if (err_q[pre].lead !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL fb_leads lead_fb: got %b want 1", err_q[pre].lead);
            end
        end
        n_cmp++;
        if (phase_err !== 9'h1FB) begin
            n_fail++;
            $display("[TB] FAIL fb_leads phase_err: got %h want 1fb", phase_err);
        end
    endtask

    // A single input held 300 cycles saturates its counter at 255.
    task automatic test_saturation();
        int fall, pre, exp_err;
        logic exp_lead;
        logic [N_BIT:0] want;
        for (int k = 0; k < 2; k++) begin
            build_wave(k, 300, 0, 2, 0);
            model_pulse(exp_err, exp_lead);
            want = (k == 0) ? 9'h0FF : 9'h101;
            pre = err_q.size();
            drive_wave(6, fall);
            n_cmp++;
            if (err_q.size() != pre + 1) begin
                n_fail++;
                $display("[TB] FAIL saturation[%0d] strobes: got %0d want 1", k, err_q.size() - pre);
            end else begin
                n_cmp++;
                if (err_q[pre].val !== (N_BIT+1)'(exp_err)) begin
                    n_fail++;
                    $display("[TB] FAIL saturation[%0d] model: got %h want %h",
                             k, err_q[pre].val, (N_BIT+1)'(exp_err));
                end
            end
            n_cmp++;
            if (phase_err !== want) begin
                n_fail++;
                $display("[TB] FAIL saturation[%0d] phase_err: got %h want %h", k, phase_err, want);
            end
        end
    endtask

    // Two pulses separated by a single low cycle are both measured.
    task automatic test_back_to_back();
        int fall_a, fall_b, pre, err_a, err_b;
        logic lead_a, lead_b;
        pre = err_q.size();
        build_wave(0, 3, 2, 1, 4);
        model_pulse(err_a, lead_a);
        drive_wave(1, fall_a);
        build_wave(1, 6, 2, 2, 0);
        model_pulse(err_b, lead_b);
        drive_wave(6, fall_b);
        n_cmp++;
        if (err_q.size() != pre + 2) begin
            n_fail++;
            $display("[TB] FAIL back_to_back strobes: got %0d want 2", err_q.size() - pre);
        end else begin
            n_cmp++;
            if (err_q[pre].val !== (N_BIT+1)'(err_a) || err_q[pre].cyc != fall_a + LAT + 1) begin
                n_fail++;
                $display("[TB] FAIL back_to_back first: got %h@%0d want %h@%0d",
                         err_q[pre].val, err_q[pre].cyc, (N_BIT+1)'(err_a), fall_a + LAT + 1);
            end
            n_cmp++;
            if (err_q[pre+1].val !== (N_BIT+1)'(err_b) || err_q[pre+1].lead !== lead_b) begin
                n_fail++;
                $display("[TB] FAIL back_to_back second: got %h lead %b want %h lead %b",
                         err_q[pre+1].val, err_q[pre+1].lead, (N_BIT+1)'(err_b), lead_b);
            end
        end
    endtask

    // Randomised pulse shapes checked against the model.
    task automatic test_random_pulses();
        int fall, pre, exp_err;
        logic exp_lead;
        for (int i = 0; i < 16; i++) begin
            build_wave($urandom_range(0, 2), $urandom_range(1, 20), $urandom_range(1, 10),
                       $urandom_range(0, 2), $urandom_range(1, 20));
            model_pulse(exp_err, exp_lead);
            pre = err_q.size();
            drive_wave(6, fall);
            n_cmp++;
            if (err_q.size() != pre + 1) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] strobes: got %0d want 1", i, err_q.size() - pre);
            end else begin
                n_cmp++;
                if (err_q[pre].val !== (N_BIT+1)'(exp_err) || err_q[pre].lead !== exp_lead
                    || err_q[pre].cyc != fall + LAT + 1) begin
                    n_fail++;
                    $display("[TB] FAIL random[%0d] result: got %h lead %b @%0d want %h lead %b @%0d",
                             i, err_q[pre].val, err_q[pre].lead, err_q[pre].cyc,
                             (N_BIT+1)'(exp_err), exp_lead, fall + LAT + 1);
                end
            end
        end
    endtask

    // Reference held 600 cycles: timeout rises exactly at MEASURE cycle
    // TIMEOUT_CYC, no strobe, and dropping the input clears it.
    task automatic test_timeout();
        int s, c, pre;
        logic [N_BIT:0] hold;
        pre  = err_q.size();
        hold = phase_err;
        s    = cyc;
        f_ref = 1'b1;
        tick(LAT + TIMEOUT_CYC);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_early: got %b at cycle %0d want 0", timeout, cyc - s);
        end
        tick(1);
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_edge: got %b at cycle %0d want 1", timeout, cyc - s);
        end
        tick(600 - LAT - TIMEOUT_CYC - 1);
        f_ref = 1'b0;
        c = cyc;
        tick(LAT);
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_hold: got %b want 1", timeout);
        end
        tick(1);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_release: got %b at %0d after fall want 0", timeout, cyc - c);
        end
        tick(6);
        n_cmp++;
        if (err_q.size() != pre || phase_err !== hold) begin
            n_fail++;
            $display("[TB] FAIL timeout_no_result: got %0d strobes, phase_err %h want 0, %h",
                     err_q.size() - pre, phase_err, hold);
        end
    endtask

    // Dropping en mid-measurement and mid-timeout aborts silently; the
    // next measurement is still correct.
    task automatic test_abort();
        int fall, pre, exp_err;
        logic exp_lead;
        logic [N_BIT:0] hold;
        pre  = err_q.size();
        hold = phase_err;
        f_ref = 1'b1;
        tick(6);
        en = 1'b0;
        tick(2);
        f_ref = 1'b0;
        tick(5);
        en = 1'b1;
        tick(4);
        n_cmp++;
        if (err_q.size() != pre || phase_err !== hold) begin
            n_fail++;
            $display("[TB] FAIL abort_measure: got %0d strobes, phase_err %h want 0, %h",
                     err_q.size() - pre, phase_err, hold);
        end
        f_ref = 1'b1;
        tick(LAT + TIMEOUT_CYC + 5);
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_tmo_setup: got %b want 1", timeout);
        end
        en = 1'b0;
        tick(1);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_tmo_fall: got %b want 0", timeout);
        end
        f_ref = 1'b0;
        tick(LAT + 3);
        en = 1'b1;
        tick(4);
        build_wave(0, 4, 2, 1, 9);
        model_pulse(exp_err, exp_lead);
        pre = err_q.size();
        drive_wave(6, fall);
        n_cmp++;
        if (err_q.size() != pre + 1 || phase_err !== (N_BIT+1)'(exp_err)) begin
            n_fail++;
            $display("[TB] FAIL abort_recover: got %0d strobes, phase_err %h want 1, %h",
                     err_q.size() - pre, phase_err, (N_BIT+1)'(exp_err));
        end
    endtask

    // Period path: first edge after reset arms only; spacings are
    // reported as-is up to 255; works with en low too.
    task automatic test_period();
        int sp[$];
        int want;
        for (int t = 0; t < 3; t++) begin
            sp.delete();
            if (t == 0) sp = '{40, 40, 40};
            else if (t == 1) sp = '{300, 2, 255, 256};
            else for (int j = 0; j < 5; j++) sp.push_back($urandom_range(2, 300));
            en = (t != 1);
            ref_edge_train(sp);
            n_cmp++;
            if (per_q.size() != sp.size()) begin
                n_fail++;
                $display("[TB] FAIL period[%0d] strobes: got %0d want %0d", t, per_q.size(), sp.size());
            end else begin
                foreach (sp[j]) begin
                    want = (sp[j] > CNT_MAX) ? CNT_MAX : sp[j];
                    n_cmp++;
                    if (per_q[j] !== N_BIT'(want)) begin
                        n_fail++;
                        $display("[TB] FAIL period[%0d][%0d] value: got %0d want %0d", t, j, per_q[j], want);
                    end
                end
            end
        end
        en = 1'b1;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_ref_leads();
        test_fb_leads();
        test_saturation();
        test_back_to_back();
        test_random_pulses();
        test_timeout();
        test_abort();
        test_period();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
